// File: rtl/sd_card_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_card_pkg                                                          |
// | Shared SD card command codes, R1 codes, tokens and write statuses.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sd_card_pkg;

    typedef enum logic [2:0] {
        NO_CMD = 3'h0,
        CMD0   = 3'h1,
        CMD8   = 3'h2,
        CMD17  = 3'h3,
        CMD24  = 3'h4,
        CMD55  = 3'h5,
        CMD58  = 3'h6,
        CMD41  = 3'h7
    } sd_cmd_t;

    localparam logic [7:0] Rsp_none          = 8'd0;
    localparam logic [7:0] Rsp_no_error      = 8'd1;
    localparam logic [7:0] Rsp_illegal_cmd   = 8'd2;
    localparam logic [7:0] Rsp_crc_error     = 8'd3;
    localparam logic [7:0] Rsp_address_error = 8'd4;
    localparam logic [7:0] Rsp_param_error   = 8'd5;

    localparam logic [7:0] c_tok_start = 8'hFE;
    localparam logic [7:0] c_tok_idle  = 8'hFF;

    localparam logic [7:0] c_wr_ok           = 8'h01;
    localparam logic [7:0] c_wr_cmd_err      = 8'h02;
    localparam logic [7:0] c_wr_crc_rej      = 8'h03;
    localparam logic [7:0] c_wr_write_err    = 8'h04;
    localparam logic [7:0] c_wr_no_token     = 8'h05;
    localparam logic [7:0] c_wr_busy_timeout = 8'h06;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD_REQ = 4'd1,
        ST_CMD_ACC = 4'd2,
        ST_CMD_RSP = 4'd3,
        ST_GAP     = 4'd4,
        ST_TOKEN   = 4'd5,
        ST_FETCH   = 4'd6,
        ST_DATA    = 4'd7,
        ST_CRC     = 4'd8,
        ST_RESP    = 4'd9,
        ST_BUSY    = 4'd10,
        ST_DONE    = 4'd11
    } wr_state_t;

    // Data-response token framing: xxx0_sss1
    function automatic logic is_data_token(input logic [7:0] b);
        return (b[4] == 1'b0) && (b[0] == 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_card_write.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_card_write                                                        |
// | SPI-mode single-block writer: CMD24, token, 512 bytes, CRC, response,|
// | busy polling. Revision: 1.0                                          |
// +----------------------------------------------------------------------+
module sd_card_write
    import sd_card_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 65535,
    parameter int RSP_MAX      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start_write,
    input  logic [31:0] i_addr,
    output logic        o_busy,
    output logic        o_write_done,
    output logic [7:0]  o_status,
    output logic [8:0]  o_addr,
    output logic        o_rd,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_spi_byte,
    output logic        o_spi_start,
    input  logic        i_spi_done,
    input  logic [7:0]  i_spi_rx,
    output logic        o_send_cmd,
    output logic [2:0]  o_cmd_select,
    output logic [31:0] o_cmd_arg,
    input  logic        i_confirm_pin,
    input  logic [7:0]  i_response_status
);

    localparam logic [15:0] c_busy_last = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] c_rsp_last  = 16'(RSP_MAX - 1);

    wr_state_t   r_state, w_state_nx;
    logic        r_pending, w_pending_nx;
    logic [9:0]  r_byte_cnt, w_byte_cnt_nx;
    logic [15:0] r_poll_cnt, w_poll_cnt_nx;
    logic        r_busy, w_busy_nx;
    logic        r_done, w_done_nx;
    logic [7:0]  r_status, w_status_nx;
    logic [8:0]  r_buf_addr, w_buf_addr_nx;
    logic        r_rd, w_rd_nx;
    logic [7:0]  r_spi_byte, w_spi_byte_nx;
    logic        r_spi_start, w_spi_start_nx;
    logic        r_send_cmd, w_send_cmd_nx;
    sd_cmd_t     r_cmd_sel, w_cmd_sel_nx;
    logic [31:0] r_cmd_arg, w_cmd_arg_nx;

    logic        w_xfer_done;
    logic        w_issue;
    logic [7:0]  w_issue_byte;
    logic        w_finish;
    logic [7:0]  w_fin_status;

    // Stray done pulses with nothing outstanding never advance the FSM
    assign w_xfer_done = r_pending & i_spi_done;

    always_comb begin
        w_state_nx     = r_state;
        w_pending_nx   = r_pending;
        w_byte_cnt_nx  = r_byte_cnt;
        w_poll_cnt_nx  = r_poll_cnt;
        w_busy_nx      = r_busy;
        w_done_nx      = 1'b0;
        w_status_nx    = r_status;
        w_buf_addr_nx  = r_buf_addr;
        w_rd_nx        = 1'b0;
        w_spi_byte_nx  = r_spi_byte;
        w_spi_start_nx = 1'b0;
        w_send_cmd_nx  = 1'b0;
        w_cmd_sel_nx   = r_cmd_sel;
        w_cmd_arg_nx   = r_cmd_arg;
        w_issue        = 1'b0;
        w_issue_byte   = c_tok_idle;
        w_finish       = 1'b0;
        w_fin_status   = r_status;

        if (w_xfer_done) w_pending_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start_write) begin
                    w_cmd_arg_nx  = i_addr;
                    w_cmd_sel_nx  = CMD24;
                    w_send_cmd_nx = 1'b1;
                    w_busy_nx     = 1'b1;
                    w_status_nx   = 8'h00;
                    w_state_nx    = ST_CMD_REQ;
                end
            end
            ST_CMD_REQ: w_state_nx = ST_CMD_ACC;
            ST_CMD_ACC: begin
                if (i_confirm_pin) begin
                    w_cmd_sel_nx = NO_CMD;
                    w_state_nx   = ST_CMD_RSP;
                end
            end
            ST_CMD_RSP: begin
                if (i_confirm_pin) begin
                    if (i_response_status == Rsp_no_error) begin
                        w_issue    = 1'b1;
                        w_state_nx = ST_GAP;
                    end else begin
                        w_finish     = 1'b1;
                        w_fin_status = c_wr_cmd_err;
                    end
                end
            end
            ST_GAP: begin
                if (w_xfer_done) begin
                    w_issue      = 1'b1;
                    w_issue_byte = c_tok_start;
                    w_state_nx   = ST_TOKEN;
                end
            end
            ST_TOKEN: begin
                if (w_xfer_done) begin
                    w_byte_cnt_nx = 10'd0;
                    w_buf_addr_nx = 9'd0;
                    w_rd_nx       = 1'b1;
                    w_state_nx    = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nx = ST_DATA;
            ST_DATA: begin
                // First DATA cycle captures the buffer byte and launches it
                if (!r_pending) begin
                    w_issue      = 1'b1;
                    w_issue_byte = i_data;
                end else if (i_spi_done) begin
                    if (r_byte_cnt == 10'd511) begin
                        w_issue       = 1'b1;
                        w_poll_cnt_nx = 16'd0;
                        w_state_nx    = ST_CRC;
                    end else begin
                        w_byte_cnt_nx = r_byte_cnt + 10'd1;
                        w_buf_addr_nx = r_byte_cnt[8:0] + 9'd1;
                        w_rd_nx       = 1'b1;
                        w_state_nx    = ST_FETCH;
                    end
                end
            end
            ST_CRC: begin
                if (w_xfer_done) begin
                    w_issue = 1'b1;
                    if (r_poll_cnt == 16'd1) begin
                        w_poll_cnt_nx = 16'd0;
                        w_state_nx    = ST_RESP;
                    end else begin
                        w_poll_cnt_nx = r_poll_cnt + 16'd1;
                    end
                end
            end
            ST_RESP: begin
                if (w_xfer_done) begin
                    if (is_data_token(i_spi_rx)) begin
                        case (i_spi_rx[3:1])
                            3'b010: begin
                                w_issue       = 1'b1;
                                w_poll_cnt_nx = 16'd0;
                                w_state_nx    = ST_BUSY;
                            end
                            3'b101: begin
                                w_finish     = 1'b1;
                                w_fin_status = c_wr_crc_rej;
                            end
                            default: begin
                                w_finish     = 1'b1;
                                w_fin_status = c_wr_write_err;
                            end
                        endcase
                    end else if (r_poll_cnt == c_rsp_last) begin
                        w_finish     = 1'b1;
                        w_fin_status = c_wr_no_token;
                    end else begin
                        w_issue       = 1'b1;
                        w_poll_cnt_nx = r_poll_cnt + 16'd1;
                    end
                end
            end
            ST_BUSY: begin
                if (w_xfer_done) begin
                    if (i_spi_rx != 8'h00) begin
                        w_finish     = 1'b1;
                        w_fin_status = c_wr_ok;
                    end else if (r_poll_cnt == c_busy_last) begin
                        w_finish     = 1'b1;
                        w_fin_status = c_wr_busy_timeout;
                    end else begin
                        w_issue       = 1'b1;
                        w_poll_cnt_nx = r_poll_cnt + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                w_busy_nx  = 1'b0;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (w_issue) begin
            w_spi_start_nx = 1'b1;
            w_spi_byte_nx  = w_issue_byte;
            w_pending_nx   = 1'b1;
        end
        if (w_finish) begin
            w_done_nx   = 1'b1;
            w_status_nx = w_fin_status;
            w_state_nx  = ST_DONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_byte_cnt  <= 10'd0;
            r_poll_cnt  <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= 8'h00;
            r_buf_addr  <= 9'd0;
            r_rd        <= 1'b0;
            r_spi_byte  <= c_tok_idle;
            r_spi_start <= 1'b0;
            r_send_cmd  <= 1'b0;
            r_cmd_sel   <= NO_CMD;
            r_cmd_arg   <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_pending   <= w_pending_nx;
            r_byte_cnt  <= w_byte_cnt_nx;
            r_poll_cnt  <= w_poll_cnt_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_status    <= w_status_nx;
            r_buf_addr  <= w_buf_addr_nx;
            r_rd        <= w_rd_nx;
            r_spi_byte  <= w_spi_byte_nx;
            r_spi_start <= w_spi_start_nx;
            r_send_cmd  <= w_send_cmd_nx;
            r_cmd_sel   <= w_cmd_sel_nx;
            r_cmd_arg   <= w_cmd_arg_nx;
        end
    end

    assign o_busy       = r_busy;
    assign o_write_done = r_done;
    assign o_status     = r_status;
    assign o_addr       = r_buf_addr;
    assign o_rd         = r_rd;
    assign o_spi_byte   = r_spi_byte;
    assign o_spi_start  = r_spi_start;
    assign o_send_cmd   = r_send_cmd;
    assign o_cmd_select = r_cmd_sel;
    assign o_cmd_arg    = r_cmd_arg;

endmodule
`default_nettype wire
